// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave register bank: default widths,
// FSM encoding and small helpers used by the datapath.
package spi_pkg;

  // Default widths shared with the SPI slave front end.
  localparam int SPI_DATA_WIDTH = 16;
  localparam int SPI_ADDR_WIDTH = 8;
  localparam int SPI_REG_NUM    = 16;

  // Direction bit (1 = read) position for the default address width.
  localparam int SPI_DIR_BIT    = SPI_ADDR_WIDTH - 1;

  // Index of the read-only status register for the default bank size.
  localparam int SPI_STATUS_IDX = SPI_REG_NUM - 1;

  // Transaction FSM states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY   = 2'd1,
    ST_COMMIT = 2'd2
  } spi_state_e;

  // Direction bit position for an arbitrary address width.
  function automatic int dir_bit_pos(input int aw);
    return aw - 1;
  endfunction

  // Status register index for an arbitrary bank size.
  function automatic int status_idx(input int reg_num);
    return reg_num - 1;
  endfunction

  // Increment an 8-bit counter, holding at all-ones.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'hFF) begin
      r = v;
    end else begin
      r = v + 8'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/spi_edge_det.sv
// Single-bit rise detector: one delay register on an already
// synchronised level, rise_o is high in the first cycle d_i is high.
module spi_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o
);

  logic d_q;

  // Delay register holding the previous-cycle level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d_i;
    end
  end

  assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/spi_reg_bank.sv
// Register bank behind the SPI slave: commits SPI writes, returns read
// data on txdata one cycle after addr, raises strobes and counts illegal
// accesses (writes to status/out of range, reads out of range).
module spi_reg_bank
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = SPI_DATA_WIDTH,
  parameter int ADDR_WIDTH = SPI_ADDR_WIDTH,
  parameter int REG_NUM    = SPI_REG_NUM
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [ADDR_WIDTH-1:0]         addr,
  input  logic                          addr_valid,
  input  logic                          spi_over,
  input  logic [DATA_WIDTH-1:0]         rxdata,
  input  logic                          txreq,
  input  logic [DATA_WIDTH-1:0]         status_in,
  output logic [DATA_WIDTH-1:0]         txdata,
  output logic [REG_NUM*DATA_WIDTH-1:0] reg_out,
  output logic                          wr_stb,
  output logic [ADDR_WIDTH-2:0]         wr_idx,
  output logic                          rd_stb,
  output logic [7:0]                    err_cnt
);

  localparam int          IW       = ADDR_WIDTH - 1;
  localparam int          RIW      = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
  localparam int          DIR_BIT  = dir_bit_pos(ADDR_WIDTH);
  // One extra bit so REG_NUM itself is representable in comparisons.
  localparam logic [IW:0] LAST_IDX = (IW+1)'(status_idx(REG_NUM));
  localparam logic [IW:0] NUM_IDX  = (IW+1)'(REG_NUM);

  spi_state_e            state_q, state_d;
  logic                  dir_q, dir_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0] regs_q [REG_NUM];
  logic [DATA_WIDTH-1:0] txdata_q, txdata_d;
  logic                  wr_stb_q, wr_stb_d;
  logic [IW-1:0]         wr_idx_q, wr_idx_d;
  logic                  rd_stb_q;
  logic [7:0]            err_q, err_d;
  logic                  we_s;
  logic                  over_rise_s;
  logic                  txreq_rise_s;
  logic [IW-1:0]         addr_idx_s;

  assign addr_idx_s = addr[IW-1:0];

  spi_edge_det u_over_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (spi_over),
    .rise_o (over_rise_s)
  );

  spi_edge_det u_txreq_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (txreq),
    .rise_o (txreq_rise_s)
  );

  // Read mux from the live address: regular register, status or zero.
  always_comb begin
    txdata_d = '0;
    if ({1'b0, addr_idx_s} < LAST_IDX) begin
      txdata_d = regs_q[addr_idx_s[RIW-1:0]];
    end else if ({1'b0, addr_idx_s} == LAST_IDX) begin
      txdata_d = status_in;
    end else begin
      txdata_d = '0;
    end
  end

  // Transaction FSM next state, commit decision and error counting.
  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    idx_d    = idx_q;
    err_d    = err_q;
    wr_stb_d = 1'b0;
    wr_idx_d = wr_idx_q;
    we_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (addr_valid) begin
          state_d = ST_BUSY;
          dir_d   = addr[DIR_BIT];
          idx_d   = addr_idx_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (addr_valid) begin
          // New address phase: previous transaction was aborted.
          dir_d = addr[DIR_BIT];
          idx_d = addr_idx_s;
        end else if (over_rise_s) begin
          if (dir_q) begin
            state_d = ST_IDLE;
            if ({1'b0, idx_q} >= NUM_IDX) begin
              err_d = sat_inc8(err_q);
            end else begin
              err_d = err_q;
            end
          end else begin
            state_d = ST_COMMIT;
          end
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
        if ({1'b0, idx_q} < LAST_IDX) begin
          we_s     = 1'b1;
          wr_stb_d = 1'b1;
          wr_idx_d = idx_q;
        end else begin
          err_d = sat_inc8(err_q);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state, captured transaction and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      dir_q    <= 1'b0;
      idx_q    <= '0;
      txdata_q <= '0;
      wr_stb_q <= 1'b0;
      wr_idx_q <= '0;
      rd_stb_q <= 1'b0;
      err_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      idx_q    <= idx_d;
      txdata_q <= txdata_d;
      wr_stb_q <= wr_stb_d;
      wr_idx_q <= wr_idx_d;
      rd_stb_q <= txreq_rise_s;
      err_q    <= err_d;
    end
  end

  // Register array; only the commit path writes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '{default: '0};
    end else if (we_s) begin
      regs_q[idx_q[RIW-1:0]] <= rxdata;
    end
  end

  for (genvar gi = 0; gi < REG_NUM; gi++) begin : g_img
    assign reg_out[gi*DATA_WIDTH +: DATA_WIDTH] = regs_q[gi];
  end

  assign txdata  = txdata_q;
  assign wr_stb  = wr_stb_q;
  assign wr_idx  = wr_idx_q;
  assign rd_stb  = rd_stb_q;
  assign err_cnt = err_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank with hand-computed expectations.
module tb_spi_reg_bank;

  logic         clk;
  logic         rst_n;
  logic [7:0]   addr;
  logic         addr_valid;
  logic         spi_over;
  logic [15:0]  rxdata;
  logic         txreq;
  logic [15:0]  status_in;
  logic [15:0]  txdata;
  logic [255:0] reg_out;
  logic         wr_stb;
  logic [6:0]   wr_idx;
  logic         rd_stb;
  logic [7:0]   err_cnt;

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  logic [255:0] exp_img;

  spi_reg_bank dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .addr       (addr),
    .addr_valid (addr_valid),
    .spi_over   (spi_over),
    .rxdata     (rxdata),
    .txreq      (txreq),
    .status_in  (status_in),
    .txdata     (txdata),
    .reg_out    (reg_out),
    .wr_stb     (wr_stb),
    .wr_idx     (wr_idx),
    .rd_stb     (rd_stb),
    .err_cnt    (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (wr_stb === 1'b1) wr_cnt = wr_cnt + 1;
    if (rd_stb === 1'b1) rd_cnt = rd_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Data phase and spi_over pulse after the address has been accepted.
  task automatic run_tail();
    addr_valid = 1'b0;
    tick();
    tick();
    spi_over = 1'b1;
    tick();
    tick();
    tick();
    spi_over = 1'b0;
    tick();
  endtask

  task automatic do_xfer(input logic [7:0] a, input logic [15:0] d);
    rxdata = d;
    addr = a;
    addr_valid = 1'b0;
    tick();
    addr_valid = 1'b1;
    tick();
    run_tail();
  endtask

  initial begin
    int wr_base;
    rst_n = 1'b0;
    addr = 8'h00;
    addr_valid = 1'b0;
    spi_over = 1'b0;
    rxdata = 16'h0000;
    txreq = 1'b0;
    status_in = 16'h0000;
    exp_img = '0;
    tick();
    tick();
    chk("rst_txdata", txdata, 16'h0000);
    chk("rst_img", reg_out, exp_img);
    chk("rst_wr_stb", wr_stb, 1'b0);
    chk("rst_rd_stb", rd_stb, 1'b0);
    chk("rst_wr_idx", wr_idx, 7'd0);
    chk("rst_err", err_cnt, 8'd0);
    rst_n = 1'b1;
    tick();

    // Write 0xA55A to index 3, spi_over held long.
    addr = 8'h03;
    tick();
    addr_valid = 1'b1;
    tick();
    addr_valid = 1'b0;
    rxdata = 16'hA55A;
    tick();
    tick();
    spi_over = 1'b1;
    tick();
    chk("wr_stb_commit_cycle", wr_stb, 1'b0);
    tick();
    chk("wr_stb_pulse", wr_stb, 1'b1);
    chk("wr_idx_3", wr_idx, 7'd3);
    chk("reg3_a55a", reg_out[63:48], 16'hA55A);
    tick();
    chk("wr_stb_drop", wr_stb, 1'b0);
    repeat (18) tick();
    chk("single_commit", wr_cnt, 1);
    spi_over = 1'b0;
    tick();
    exp_img[63:48] = 16'hA55A;

    // Read index 3, txdata valid in the addr_valid cycle.
    addr = 8'h83;
    tick();
    addr_valid = 1'b1;
    chk("rd3_txdata", txdata, 16'hA55A);
    tick();
    addr_valid = 1'b0;
    txreq = 1'b1;
    tick();
    chk("rd_stb_pulse", rd_stb, 1'b1);
    tick();
    chk("rd_stb_drop", rd_stb, 1'b0);
    tick();
    spi_over = 1'b1;
    tick();
    tick();
    txreq = 1'b0;
    spi_over = 1'b0;
    tick();
    chk("rd_stb_once", rd_cnt, 1);
    chk("rd_no_write", wr_cnt, 1);
    chk("rd_no_err", err_cnt, 8'd0);

    // Status read and rejected status write.
    status_in = 16'h1234;
    addr = 8'h8F;
    tick();
    addr_valid = 1'b1;
    chk("status_txdata", txdata, 16'h1234);
    tick();
    run_tail();
    chk("status_rd_no_err", err_cnt, 8'd0);
    do_xfer(8'h0F, 16'hBEEF);
    chk("status_wr_img", reg_out, exp_img);
    chk("status_wr_no_stb", wr_cnt, 1);
    chk("status_wr_err", err_cnt, 8'd1);

    // Out-of-range write and read.
    do_xfer(8'h20, 16'h1111);
    chk("oor_wr_err", err_cnt, 8'd2);
    addr = 8'hA0;
    tick();
    addr_valid = 1'b1;
    chk("oor_txdata", txdata, 16'h0000);
    tick();
    run_tail();
    chk("oor_rd_err", err_cnt, 8'd3);
    chk("oor_img", reg_out, exp_img);
    chk("oor_no_stb", wr_cnt, 1);

    // Aborted transaction to 5, then completed write to 6.
    rxdata = 16'h00FF;
    addr = 8'h05;
    tick();
    addr_valid = 1'b1;
    tick();
    addr_valid = 1'b0;
    addr = 8'h06;
    tick();
    addr_valid = 1'b1;
    tick();
    run_tail();
    exp_img[111:96] = 16'h00FF;
    chk("abort_reg6", reg_out[111:96], 16'h00FF);
    chk("abort_reg5", reg_out[95:80], 16'h0000);
    chk("abort_img", reg_out, exp_img);
    chk("abort_wr_idx", wr_idx, 7'd6);
    chk("abort_one_stb", wr_cnt, 2);
    chk("abort_no_err", err_cnt, 8'd3);

    // Saturation of the error counter.
    for (int i = 0; i < 300; i++) begin
      do_xfer(8'h0F, 16'(i));
    end
    chk("err_saturate", err_cnt, 8'd255);
    chk("sat_img", reg_out, exp_img);

    // Reset during BUSY with spi_over high.
    rxdata = 16'h7777;
    addr = 8'h07;
    tick();
    addr_valid = 1'b1;
    tick();
    addr_valid = 1'b0;
    tick();
    wr_base = wr_cnt;
    spi_over = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_img", reg_out, 256'd0);
    chk("mid_rst_err", err_cnt, 8'd0);
    chk("mid_rst_wr_idx", wr_idx, 7'd0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("post_rst_no_write", wr_cnt, wr_base);
    chk("post_rst_img", reg_out, 256'd0);
    chk("post_rst_txdata", txdata, 16'h0000);
    chk("post_rst_err", err_cnt, 8'd0);
    chk("post_rst_wr_stb", wr_stb, 1'b0);
    chk("post_rst_rd_stb", rd_stb, 1'b0);
    spi_over = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_reg_bank.md
# spi_reg_bank

Register bank sitting directly downstream of the SPI slave front end. It consumes the slave's decoded address, received data and transaction markers, commits SPI writes into a bank of `REG_NUM` control registers, and supplies read data back to the slave's `txdata` input in time for it to be latched. It also exposes the registers to the fabric, raises per-transaction strobes, and counts illegal accesses.

## Interface
Parameters:
- `DATA_WIDTH`, 16, register and SPI data width
- `ADDR_WIDTH`, 8, SPI address width; the MSB is the direction bit (1 = read), the low `ADDR_WIDTH-1` bits are the register index
- `REG_NUM`, 16, number of registers; index `REG_NUM-1` is the read-only status register

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  reset; one clock, asynchronous, active-low
- `addr`  in  `ADDR_WIDTH`  address from the SPI slave
- `addr_valid`  in  1  high for one cycle when `addr` is complete
- `spi_over`  in  1  high from the end of the data phase until CS deasserts
- `rxdata`  in  `DATA_WIDTH`  write data from the SPI slave
- `txreq`  in  1  slave read-phase indicator
- `status_in`  in  `DATA_WIDTH`  live value returned at index `REG_NUM-1`
- `txdata`  out  `DATA_WIDTH`  read data to the SPI slave
- `reg_out`  out  `REG_NUM*DATA_WIDTH`  flat register image; register i is at `[i*DATA_WIDTH +: DATA_WIDTH]`
- `wr_stb`  out  1  one-cycle pulse on each committed write
- `wr_idx`  out  `ADDR_WIDTH-1`  index of the last committed write
- `rd_stb`  out  1  one-cycle pulse on the rising edge of `txreq`
- `err_cnt`  out  8  saturating count of illegal accesses

## Operation
- Reset values: all registers, `txdata`, `wr_idx` and `err_cnt` are 0; `wr_stb` and `rd_stb` are 0; the FSM is in IDLE.
- FSM states: IDLE, BUSY, COMMIT.
  - IDLE → BUSY on `addr_valid`. On this transition the block captures `dir_q = addr[MSB]` and `idx_q = addr[ADDR_WIDTH-2:0]`.
  - BUSY → COMMIT on the rising edge of `spi_over`, but only when `dir_q == 0`.
  - BUSY → IDLE on the rising edge of `spi_over` when `dir_q == 1`.
  - COMMIT → IDLE after one cycle.
  - In BUSY, a fresh `addr_valid` means the previous transaction was aborted. The block recaptures `dir_q`/`idx_q` and stays in BUSY. No write, no error count.
- COMMIT behaviour:
  - If `idx_q < REG_NUM-1`: `reg[idx_q] <= rxdata`, `wr_stb = 1`, `wr_idx <= idx_q`.
  - Otherwise (status register or out of range): the write is dropped and `err_cnt` increments.
- Reads (`dir_q == 1`) with `idx_q >= REG_NUM` increment `err_cnt` on the BUSY→IDLE transition.
- `err_cnt` saturates at 255.
- Edge detection of `spi_over` and `txreq` uses one delay register each on the already-synchronised slave outputs. `spi_over` stays high until CS rises, so each transaction commits at most once.

## Timing
- `txdata` is registered every cycle from the live `addr` input, one cycle of latency:
  - `regs[idx]` when `idx < REG_NUM-1`
  - `status_in` when `idx == REG_NUM-1`
  - 0 when `idx >= REG_NUM`
- The slave holds `addr` stable for at least one cycle before `addr_valid` and latches `txdata` in the `addr_valid` cycle. `txdata` is therefore valid in that cycle. This is a hard requirement.
- Write latency: `spi_over` rise at cycle t → COMMIT at t+1. The register, `reg_out` and `wr_stb` all update at the edge ending cycle t+1.
- A write commit and a `txdata` refresh in the same cycle: `txdata` shows the old value and the new value one cycle later. No bypass is needed, because the next address phase spans at least `ADDR_WIDTH` SCK periods.
- `rd_stb` is asserted in the cycle after `txreq` rises.
- Asserting `rst_n` mid-transaction clears everything immediately. A `spi_over` that is still high after reset release does not commit, because the edge register resets to 0 and the FSM is in IDLE, not BUSY.

## Structure
- Shared package `spi_pkg`: FSM state encodings (IDLE/BUSY/COMMIT), the direction-bit position, the status-index constant `REG_NUM-1`, and the default widths shared with the slave.
- One sub-module is natural: `spi_edge_det`, a single-bit rise-detect register instantiated for `spi_over` and `txreq`.
- The register array, read mux and FSM stay in the top.

## Test plan
- Write 0xA55A to index 3 (address 0x03): `wr_stb` is asserted for exactly one cycle, `wr_idx = 3`, and `reg_out[63:48] = 0xA55A`. `spi_over` is then held high for 20 cycles: no second `wr_stb`.
- Read index 3 (address 0x83) after the previous write: `txdata = 0xA55A` in the `addr_valid` cycle, and `rd_stb` pulses once after `txreq` rises.
- Read the status register (address 0x8F) with `status_in = 0x1234`: `txdata = 0x1234`. Writing address 0x0F leaves the registers unchanged, gives no `wr_stb`, and `err_cnt = 1`.
- Out-of-range access: write address 0x20 and read address 0xA0. `txdata = 0`, no register changes, `err_cnt` goes up by 2. Forcing 300 illegal accesses leaves `err_cnt = 255`.
- Abort: `addr_valid` for address 0x05, then a second `addr_valid` for 0x06 before any `spi_over`, then `spi_over` with `rxdata = 0x00FF`. Only reg 6 = 0x00FF; reg 5 is unchanged.
- Pull `rst_n` low during BUSY with `spi_over` high, then release it: all outputs are 0 and no write occurs after release.
